// File: rtl/chan_pipe_pkg.sv
// Shared defaults and helpers for the chan_pipe channel merger.
// chan_w() sizes the source-channel tag and never returns less than one bit.
package chan_pipe_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int CHANNELS_DEF = 4;
  localparam int DEPTH_DEF    = 4;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_pipe_fifo.sv
// Per-channel FIFO: write-to-read latency of one edge; wr_rdy_o comes only from the registered count.
// A full FIFO stays not-ready for the whole cycle, even when it is popped on that same edge.
module chan_pipe_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             wr_rdy_o,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             ne_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  assign wr_rdy_o = (cnt_q < FULL);
  assign ne_o     = (cnt_q != '0);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign push     = wr_vld_i & wr_rdy_o;
  assign pop      = rd_i & ne_o;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/chan_pipe.sv
// Merges CHANNELS FIFO-buffered inputs round-robin into one registered output, one cycle after the FIFO write.
// The output register holds while VALID_O && !READY_I; optional PARITY_O under `CHAN_PIPE_PARITY_EN.
module chan_pipe
  import chan_pipe_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic [CHANNELS*WIDTH-1:0] DATA_I,
  input  logic [CHANNELS-1:0]       VALID_I,
  output logic [CHANNELS-1:0]       READY_O,
  output logic [WIDTH-1:0]          DATA_O,
  output logic [chan_w(CHANNELS)-1:0] CHAN_O,
  output logic                      VALID_O,
`ifdef CHAN_PIPE_PARITY_EN
  output logic                      PARITY_O,
`endif
  input  logic                      READY_I
);

  localparam int CW = chan_w(CHANNELS);

  logic [WIDTH-1:0]    fifo_dat [CHANNELS];
  logic [CHANNELS-1:0] ne;
  logic [CHANNELS-1:0] pop;

  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic [CW-1:0]    last_q, last_d;
  logic             vld_q, vld_d;
  logic             grant_vld;
  logic [CW-1:0]    grant_idx;
  logic [WIDTH-1:0] grant_dat;
  logic             load;
  int               idx;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_fifo
    chan_pipe_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk_i    (CLK_I),
      .rst_i    (RST_I),
      .wr_vld_i (VALID_I[c]),
      .wr_dat_i (DATA_I[c*WIDTH +: WIDTH]),
      .wr_rdy_o (READY_O[c]),
      .rd_i     (pop[c]),
      .rd_dat_o (fifo_dat[c]),
      .ne_o     (ne[c])
    );
  end

  // Round-robin: first non-empty channel at or after last_q+1.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(last_q) + 1 + i) % CHANNELS;
      if (!grant_vld && ne[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(idx);
      end
    end
  end

  assign grant_dat = fifo_dat[grant_idx];
  assign load      = (!vld_q || READY_I) && grant_vld;

  always_comb begin
    pop    = '0;
    vld_d  = vld_q;
    dat_d  = dat_q;
    chan_d = chan_q;
    last_d = last_q;
    if (load) begin
      pop[grant_idx] = 1'b1;
      vld_d          = 1'b1;
      dat_d          = grant_dat;
      chan_d         = grant_idx;
      last_d         = grant_idx;
    end else if (READY_I) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      chan_q <= '0;
      last_q <= CW'(CHANNELS - 1);
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      chan_q <= chan_d;
      last_q <= last_d;
    end
  end

  assign VALID_O = vld_q;
  assign DATA_O  = dat_q;
  assign CHAN_O  = chan_q;

`ifdef CHAN_PIPE_PARITY_EN
  logic par_q, par_d;

  assign par_d = load ? ^grant_dat : par_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) par_q <= 1'b0;
    else       par_q <= par_d;
  end

  assign PARITY_O = par_q;
`endif

endmodule

// File: tb/tb_chan_pipe.sv
// Bench for chan_pipe at default parameters: directed vector table, hand sequences, then a
// randomized run checked against a queue-based reference model.
module tb_chan_pipe;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int D  = 4;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic [CH*W-1:0] DATA_I;
  logic [CH-1:0] VALID_I;
  logic [CH-1:0] READY_O;
  logic [W-1:0]  DATA_O;
  logic [1:0]    CHAN_O;
  logic          VALID_O;
  logic          READY_I;
`ifdef CHAN_PIPE_PARITY_EN
  logic          PARITY_O;
`endif

  chan_pipe #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .DATA_I  (DATA_I),
    .VALID_I (VALID_I),
    .READY_O (READY_O),
    .DATA_O  (DATA_O),
    .CHAN_O  (CHAN_O),
    .VALID_O (VALID_O),
`ifdef CHAN_PIPE_PARITY_EN
    .PARITY_O(PARITY_O),
`endif
    .READY_I (READY_I)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic        rdy;
    logic        exp_vld;
    logic [7:0]  exp_dat;
    logic [1:0]  exp_chan;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t tbl [16];

  // Reference model: one queue per channel plus the output register contents.
  typedef logic [7:0] wq_t [$];
  wq_t        mq [CH];
  logic       m_vld;
  logic [7:0] m_dat;
  int         m_chan;
  int         m_last;

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_vld = 1'b0; m_dat = 8'h00; m_chan = 0; m_last = CH - 1;
  endtask

  task automatic model_step(input logic [3:0] vld, input logic [31:0] dat, input logic rdy);
    logic [3:0] acc;
    bit found;
    for (int c = 0; c < CH; c++) acc[c] = vld[c] && (mq[c].size() < D);
    if (!m_vld || rdy) begin
      found = 0;
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (m_last + 1 + i) % CH;
        if (!found && mq[c].size() > 0) begin
          found  = 1;
          m_dat  = mq[c].pop_front();
          m_chan = c;
          m_last = c;
        end
      end
      m_vld = found;
    end
    for (int c = 0; c < CH; c++)
      if (acc[c]) mq[c].push_back(dat[c*8 +: 8]);
  endtask

  task automatic cmp_model(input string tag);
    logic [3:0] r;
    for (int c = 0; c < CH; c++) r[c] = (mq[c].size() < D);
    chk({tag, " valid"}, 32'(VALID_O), 32'(m_vld));
    chk({tag, " data"},  32'(DATA_O),  32'(m_dat));
    chk({tag, " chan"},  32'(CHAN_O),  32'(m_chan));
    chk({tag, " ready"}, 32'(READY_O), 32'(r));
`ifdef CHAN_PIPE_PARITY_EN
    chk({tag, " parity"}, 32'(PARITY_O), 32'(^m_dat));
`endif
  endtask

  initial begin
    //              vld      dat           rdy   vld   dat    chan  ready
    tbl[0]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'hF};
    tbl[1]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 8'h00, 2'd0, 4'hF};
    tbl[2]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'hA5, 2'd2, 4'hF};
    tbl[3]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'hA5, 2'd2, 4'hF};
    tbl[4]  = '{4'b0001, 32'h0000_0011, 1'b0, 1'b0, 8'hA5, 2'd2, 4'hF};
    tbl[5]  = '{4'b0001, 32'h0000_0022, 1'b0, 1'b1, 8'h11, 2'd0, 4'hF};
    tbl[6]  = '{4'b0001, 32'h0000_0033, 1'b0, 1'b1, 8'h11, 2'd0, 4'hF};
    tbl[7]  = '{4'b0001, 32'h0000_0044, 1'b0, 1'b1, 8'h11, 2'd0, 4'hF};
    tbl[8]  = '{4'b0001, 32'h0000_0055, 1'b0, 1'b1, 8'h11, 2'd0, 4'hE};
    tbl[9]  = '{4'b0001, 32'h0000_0066, 1'b0, 1'b1, 8'h11, 2'd0, 4'hE};
    tbl[10] = '{4'b0000, 32'h0000_0000, 1'b0, 1'b1, 8'h11, 2'd0, 4'hE};
    tbl[11] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h22, 2'd0, 4'hF};
    tbl[12] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h33, 2'd0, 4'hF};
    tbl[13] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h44, 2'd0, 4'hF};
    tbl[14] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b1, 8'h55, 2'd0, 4'hF};
    tbl[15] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 8'h55, 2'd0, 4'hF};

    RST_I = 1'b1; VALID_I = '0; DATA_I = '0; READY_I = 1'b0;
    repeat (2) @(posedge CLK_I);
    #1;
    chk("in_reset valid", 32'(VALID_O), 32'd0);
    chk("in_reset data",  32'(DATA_O),  32'd0);
    RST_I = 1'b0;

    // Directed table: single word latency, drain-to-idle, ch0 backpressure fill and ordered drain.
    for (int i = 0; i < 16; i++) begin
      VALID_I = tbl[i].vld; DATA_I = tbl[i].dat; READY_I = tbl[i].rdy;
      @(posedge CLK_I); #1;
      chk($sformatf("tbl%0d valid", i), 32'(VALID_O), 32'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d data", i),  32'(DATA_O),  32'(tbl[i].exp_dat));
      chk($sformatf("tbl%0d chan", i),  32'(CHAN_O),  32'(tbl[i].exp_chan));
      chk($sformatf("tbl%0d ready", i), 32'(READY_O), 32'(tbl[i].exp_ready));
    end

    // Round-robin with every channel holding two words.
    RST_I = 1'b1; VALID_I = '0; READY_I = 1'b0;
    #2;
    RST_I = 1'b0;
    @(posedge CLK_I); #1;
    VALID_I = 4'hF; DATA_I = 32'hA3A2_A1A0;
    @(posedge CLK_I); #1;
    DATA_I = 32'hB3B2_B1B0;
    @(posedge CLK_I); #1;
    VALID_I = '0;
    chk("rr0 chan", 32'(CHAN_O), 32'd0);
    chk("rr0 data", 32'(DATA_O), 32'hA0);
    READY_I = 1'b1;
    for (int j = 1; j < 8; j++) begin
      @(posedge CLK_I); #1;
      chk($sformatf("rr%0d chan", j), 32'(CHAN_O), 32'(j % 4));
      chk($sformatf("rr%0d data", j), 32'(DATA_O), 32'(((j < 4) ? 8'hA0 : 8'hB0) + j % 4));
    end

    // Reset while ch1 holds three words and the output is valid.
    READY_I = 1'b0; VALID_I = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      DATA_I = 32'(8'hC0 + k) << 8;
      @(posedge CLK_I); #1;
    end
    VALID_I = '0;
    chk("pre_rst valid", 32'(VALID_O), 32'd1);
    #2;
    RST_I = 1'b1;
    #1;
    chk("rst valid", 32'(VALID_O), 32'd0);
    chk("rst data",  32'(DATA_O),  32'd0);
    chk("rst chan",  32'(CHAN_O),  32'd0);
    chk("rst ready", 32'(READY_O), 32'hF);
    RST_I = 1'b0;
    READY_I = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK_I); #1;
      chk($sformatf("post_rst%0d valid", k), 32'(VALID_O), 32'd0);
    end

    // Randomized traffic against the reference model.
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        RST_I = 1'b1;
        #1;
        model_reset();
        cmp_model("rand_rst");
        RST_I = 1'b0;
      end
      VALID_I = 4'($urandom);
      DATA_I  = $urandom;
      READY_I = ($urandom_range(0, 9) < 7);
      @(posedge CLK_I);
      model_step(VALID_I, DATA_I, READY_I);
      #1;
      cmp_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
